// File: rtl/aes128_iter_if.sv
// Host-side handshake bundle for the iterative AES-128 sequencer.
// The host owns master; the sequencer owns slave.
interface aes128_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext
    );
    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext
    );
endinterface

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 sequencer: one round per clock through an external round datapath,
// with on-the-fly key expansion and valid/ready handshakes on both sides.

// One S-box lane: multiplicative inverse in GF(2^8) followed by the affine map.
module aes128_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 (and maps 0 to 0, as the S-box needs)
    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 0; i < 7; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    assign s = sbox_f(a);
endmodule

module aes128_iter_ctrl #(
    parameter int         NR      = 10,
    parameter logic [7:0] RC_INIT = 8'h01
) (
    input  logic           clk,
    input  logic           rst,
    aes128_iter_if.slave   host,
    output logic           busy,
    output logic [127:0]   rnd_state,
    output logic [127:0]   rnd_key,
    output logic           rnd_final,
    input  logic [127:0]   rnd_result
);
    localparam int         NUM_LANES = 4;
    localparam logic [3:0] LAST_RND  = 4'(NR);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t         fsm;
    logic [3:0]   round;
    logic [7:0]   rcon;
    logic [127:0] state_q;
    logic [127:0] rk_q;
    logic [127:0] ct_q;
    logic         ov_q;

    // SubWord(RotWord(w3)) across four S-box lanes
    logic [NUM_LANES-1:0][7:0] sw_in;
    logic [NUM_LANES-1:0][7:0] sw_out;

    assign sw_in = {rk_q[23:0], rk_q[31:24]};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_sbox
        aes128_sbox u_sbox (.a(sw_in[i]), .s(sw_out[i]));
    end

    logic [31:0]  w3t, w0n, w1n, w2n, w3n;
    logic [127:0] next_rk;
    logic [7:0]   rcon_nxt;

    assign w3t      = sw_out ^ {rcon, 24'h0};
    assign w0n      = rk_q[127:96] ^ w3t;
    assign w1n      = rk_q[95:64]  ^ w0n;
    assign w2n      = rk_q[63:32]  ^ w1n;
    assign w3n      = rk_q[31:0]   ^ w2n;
    assign next_rk  = {w0n, w1n, w2n, w3n};
    assign rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    assign host.in_ready   = (fsm == IDLE) && !rst;
    assign host.out_valid  = ov_q;
    assign host.ciphertext = ct_q;
    assign busy            = (fsm != IDLE);
    assign rnd_state       = (fsm == ROUND) ? state_q : '0;
    assign rnd_key         = (fsm == ROUND) ? next_rk : '0;
    assign rnd_final       = (fsm == ROUND) && (round == LAST_RND);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm     <= IDLE;
            round   <= '0;
            rcon    <= RC_INIT;
            state_q <= '0;
            rk_q    <= '0;
            ct_q    <= '0;
            ov_q    <= 1'b0;
        end else begin
            case (fsm)
                IDLE: if (host.in_valid) begin
                    // pre-whitening folded into the accept edge
                    state_q <= host.plaintext ^ host.key;
                    rk_q    <= host.key;
                    round   <= 4'd1;
                    rcon    <= RC_INIT;
                    fsm     <= ROUND;
                end
                ROUND: begin
                    state_q <= rnd_result;
                    rk_q    <= next_rk;
                    rcon    <= rcon_nxt;
                    round   <= round + 4'd1;
                    if (round == LAST_RND) begin
                        ct_q <= rnd_result;
                        ov_q <= 1'b1;
                        fsm  <= DONE;
                    end
                end
                DONE: if (host.out_ready) begin
                    ov_q <= 1'b0;
                    fsm  <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Bench for aes128_iter_ctrl: supplies the round datapath and checks against a
// byte-array AES-128 reference (FIPS-197 vectors plus random scoreboarded jobs).
module tb_aes128_iter_ctrl;
    localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         busy;
    logic [127:0] rnd_state, rnd_key, rnd_result;
    logic         rnd_final;
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] rk_ref [11];

    aes128_iter_if bus ();

    aes128_iter_ctrl dut (
        .clk(clk), .rst(rst), .host(bus), .busy(busy),
        .rnd_state(rnd_state), .rnd_key(rnd_key), .rnd_final(rnd_final),
        .rnd_result(rnd_result)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p = 8'h00;
        logic [7:0] t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = xt(t);
        end
        return p;
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] tb_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) a[i] = sbox_t[gb(s, i)];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) b[r+4*c] = a[r+4*((c+r)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a[0] = b[4*c]; a[1] = b[4*c+1]; a[2] = b[4*c+2]; a[3] = b[4*c+3];
                b[4*c]   = gm(a[0], 8'h02) ^ gm(a[1], 8'h03) ^ a[2] ^ a[3];
                b[4*c+1] = a[0] ^ gm(a[1], 8'h02) ^ gm(a[2], 8'h03) ^ a[3];
                b[4*c+2] = a[0] ^ a[1] ^ gm(a[2], 8'h02) ^ gm(a[3], 8'h03);
                b[4*c+3] = gm(a[0], 8'h03) ^ a[1] ^ a[2] ^ gm(a[3], 8'h02);
            end
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = b[i] ^ gb(k, i);
        return res;
    endfunction

    assign rnd_result = tb_round(rnd_state, rnd_key, rnd_final);

    task automatic build_sbox();
        logic [7:0] inv, o;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            sbox_t[x] = o ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_ref[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic aes_ref(input logic [127:0] pt, input logic [127:0] k, output logic [127:0] ct);
        expand(k);
        ct = pt ^ k;
        for (int r = 1; r <= 10; r++) ct = tb_round(ct, rk_ref[r], r == 10);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Run one job; optionally check round-1/round-10 keys against constants, then hold DONE.
    task automatic run_job(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] exp_ct,
                           input bit kc, input int hold);
        int n = 0;
        int finals = 0;
        logic [127:0] ct0;
        expand(k);
        bus.plaintext = pt; bus.key = k; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        while (!bus.in_ready && n < 40) begin step(); n++; end
        chk("accept_wait", 128'(n < 40), 128'd1);
        step();
        bus.in_valid = 1'b0; bus.plaintext = rnd128(); bus.key = rnd128();
        for (int r = 1; r <= 10; r++) begin
            chk("rnd_key", rnd_key, rk_ref[r]);
            chk("rnd_final", 128'(rnd_final), 128'(r == 10));
            chk("early_valid", 128'(bus.out_valid), 128'd0);
            if (kc && r == 1)  chk("rk1_const", rnd_key, RK1);
            if (kc && r == 10) chk("rk10_const", rnd_key, RK10);
            if (rnd_final) finals++;
            step();
        end
        chk("latency_valid", 128'(bus.out_valid), 128'd1);
        chk("final_count", 128'(finals), 128'd1);
        chk("ciphertext", bus.ciphertext, exp_ct);
        ct0 = bus.ciphertext;
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = h[0];
            step();
            chk("bp_stable", bus.ciphertext, ct0);
            chk("bp_valid", 128'(bus.out_valid), 128'd1);
            chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("release_valid", 128'(bus.out_valid), 128'd0);
        chk("release_in_ready", 128'(bus.in_ready), 128'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] exp, pt, k;
        logic [127:0] exp_q [$];
        int got, acc, last_acc, seen;

        build_sbox();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.plaintext = '0; bus.key = '0;
        step(); step();
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ciphertext", bus.ciphertext, 128'd0);
        chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 128'(bus.in_ready), 128'd1);

        // FIPS-197 App.B and App.C.1
        run_job(PT1, KEY1, CT1, 1'b1, 0);
        run_job(PT2, KEY2, CT2, 1'b0, 0);

        // backpressure in DONE, then a job afterwards
        run_job(PT2, KEY2, CT2, 1'b0, 5);
        pt = rnd128(); k = rnd128(); aes_ref(pt, k, exp);
        run_job(pt, k, exp, 1'b0, 2);

        // reset during round 5 must abort without emitting
        bus.plaintext = PT1; bus.key = KEY1; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("mid_busy_before_rst", 128'(busy), 128'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", 128'(bus.in_ready), 128'd1);
        bus.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.out_valid) seen++;
            step();
        end
        bus.out_ready = 1'b0;
        chk("mid_rst_no_emit", 128'(seen), 128'd0);
        run_job(PT1, KEY1, CT1, 1'b0, 0);

        // back-to-back random jobs, scoreboarded in order
        got = 0; acc = 0; last_acc = 0;
        pt = rnd128(); k = rnd128();
        bus.plaintext = pt; bus.key = k; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int c = 0; c < 120 && got < 6; c++) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) chk("b2b_unexpected", 128'd1, 128'd0);
                else chk("b2b_ciphertext", bus.ciphertext, exp_q.pop_front());
                got++;
            end
            if (bus.in_ready && bus.in_valid) begin
                aes_ref(pt, k, exp);
                exp_q.push_back(exp);
                if (acc > 0) chk("b2b_gap", 128'(cyc - last_acc), 128'd12);
                last_acc = cyc;
                acc++;
                step();
                pt = rnd128(); k = rnd128();
                bus.plaintext = pt; bus.key = k;
                if (acc == 6) bus.in_valid = 1'b0;
            end else begin
                step();
            end
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        chk("b2b_count", 128'(got), 128'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
